// File: rtl/mdio_phy_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdio_phy_responder_pkg
// Description : Shared constants, FSM state type and register default table
//               for the Clause 22 MDIO PHY responder.
// Revision    : 1.0 - initial release
// ============================================================================
package mdio_phy_responder_pkg;

  // Frame field codes, MSB first on the wire
  localparam logic [1:0] ST_CODE  = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] TA_WRITE = 2'b10;

  // Field lengths expressed as the last value of the 5-bit bit counter
  localparam logic [4:0] ADDR_LAST = 5'd4;   // PHYAD / REGAD are 5 bits
  localparam logic [4:0] DATA_LAST = 5'd15;  // 16 data bits
  localparam logic [4:0] SKIP_LAST = 5'd17;  // TA + data of a foreign frame
  localparam logic [4:0] RD_DONE   = 5'd16;  // all read bits have been driven

  typedef enum logic [3:0] {
    S_HUNT    = 4'd0,
    S_ST1     = 4'd1,
    S_OP      = 4'd2,
    S_PHYAD   = 4'd3,
    S_REGAD   = 4'd4,
    S_RD_TA   = 4'd5,
    S_WR_TA   = 4'd6,
    S_SKIP    = 4'd7,
    S_RD_DATA = 4'd8,
    S_WR_DATA = 4'd9
  } state_e;

  // Power-on contents of the emulated Marvell PHY register map
  function automatic logic [15:0] default_reg(input logic [4:0] idx);
    logic [15:0] val;
    case (idx)
      5'd0:    val = 16'h1140;
      5'd1:    val = 16'h7949;
      5'd2:    val = 16'h0141;
      5'd3:    val = 16'h0CC2;
      5'd4:    val = 16'h01E1;
      5'd6:    val = 16'h0004;
      5'd7:    val = 16'h2001;
      5'd9:    val = 16'h0F00;
      5'd10:   val = 16'h4000;
      5'd15:   val = 16'h3000;
      5'd16:   val = 16'h0308;
      5'd17:   val = 16'h8110;
      5'd19:   val = 16'h0010;
      5'd20:   val = 16'h0C60;
      5'd24:   val = 16'h4100;
      5'd26:   val = 16'h000A;
      5'd27:   val = 16'h848B;
      default: val = 16'h0000;
    endcase
    return val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdio_phy_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : mdio_phy_responder_if
// Description : Status/event bundle produced by the MDIO PHY responder.
//               o_mdio_oe mirrors the tristate enable of the MDIO line.
// Revision    : 1.0 - initial release
// ============================================================================
interface mdio_phy_responder_if;
  logic        o_wr_strobe;
  logic [4:0]  o_wr_addr;
  logic [15:0] o_wr_data;
  logic        o_rd_strobe;
  logic        o_frame_err;
  logic        o_busy;
  logic        o_mdio_oe;

  // Responder side drives everything
  modport slave (
    output o_wr_strobe, o_wr_addr, o_wr_data, o_rd_strobe,
           o_frame_err, o_busy, o_mdio_oe
  );

  // Observer / consumer side
  modport master (
    input  o_wr_strobe, o_wr_addr, o_wr_data, o_rd_strobe,
           o_frame_err, o_busy, o_mdio_oe
  );
endinterface
`default_nettype wire

// File: rtl/mdio_phy_responder_regfile.sv
`default_nettype none
// ============================================================================
// Module      : mdio_phy_responder_regfile
// Description : 32x16 PHY register file. Async reset to the default table,
//               one write port gated by a read-only mask, combinational read.
// Revision    : 1.0 - initial release
// ============================================================================
module mdio_phy_responder_regfile
  import mdio_phy_responder_pkg::*;
#(
  parameter logic [31:0] RO_MASK = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [15:0] i_wdata,
  input  logic [4:0]  i_raddr,
  output logic [15:0] o_rdata
);

  logic [15:0] mem_q [32];

  // Register storage: reload defaults on reset, drop writes to read-only entries
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < 32; i++) begin
        mem_q[i] <= default_reg(5'(i));
      end
    end else if (i_we && !RO_MASK[i_waddr]) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule
`default_nettype wire

// File: rtl/mdio_phy_responder.sv
`default_nettype none
// ============================================================================
// Module      : mdio_phy_responder
// Description : Clause 22 MDIO PHY-side responder. Hunts for preamble,
//               decodes ST/OP/PHYAD/REGAD, serves reads by driving the line
//               during TA/data and commits writes to the register file.
//               i_clk is MDC; one bit per clock, all sampling on posedge.
// Revision    : 1.0 - initial release
// ============================================================================
module mdio_phy_responder
  import mdio_phy_responder_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR     = 5'd0,
  parameter int unsigned PREAMBLE_MIN = 32,
  parameter logic [31:0] RO_MASK      = 32'h0
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  inout  wire                  io_mdio,
  mdio_phy_responder_if.slave  status
);

  // Preamble count saturates here; 6 bits covers any practical minimum
  localparam logic [5:0] PRE_SAT = 6'(PREAMBLE_MIN);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [5:0]  ones_q, ones_d;
  logic [15:0] sh_q, sh_d;
  logic [1:0]  op_q, op_d;
  logic        match_q, match_d;
  logic        rd_q, rd_d;
  logic [4:0]  regad_q, regad_d;
  logic        ta_q, ta_d;
  logic [15:0] tx_q, tx_d;
  logic        oe_q, oe_d;
  logic        out_q, out_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        rd_strobe_q, rd_strobe_d;
  logic        frame_err_q, frame_err_d;

  logic        mdio_bit;
  logic        rf_we;
  logic [4:0]  rf_raddr;
  logic [15:0] rf_wdata;
  logic [15:0] rf_rdata;

  // Undriven or unknown line reads as 1: the bus is pulled up
  assign mdio_bit = (io_mdio === 1'b0) ? 1'b0 : 1'b1;
  assign io_mdio  = oe_q ? out_q : 1'bz;

  mdio_phy_responder_regfile #(
    .RO_MASK (RO_MASK)
  ) u_regfile (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_we      (rf_we),
    .i_waddr   (regad_q),
    .i_wdata   (rf_wdata),
    .i_raddr   (rf_raddr),
    .o_rdata   (rf_rdata)
  );

  // State and datapath registers; reset releases the line immediately
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= S_HUNT;
      cnt_q       <= '0;
      ones_q      <= '0;
      sh_q        <= '0;
      op_q        <= '0;
      match_q     <= 1'b0;
      rd_q        <= 1'b0;
      regad_q     <= '0;
      ta_q        <= 1'b0;
      tx_q        <= '0;
      oe_q        <= 1'b0;
      out_q       <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ones_q      <= ones_d;
      sh_q        <= sh_d;
      op_q        <= op_d;
      match_q     <= match_d;
      rd_q        <= rd_d;
      regad_q     <= regad_d;
      ta_q        <= ta_d;
      tx_q        <= tx_d;
      oe_q        <= oe_d;
      out_q       <= out_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_strobe_q <= rd_strobe_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Frame decoder: next state, shift registers, line drive and event pulses
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ones_d      = ones_q;
    sh_d        = sh_q;
    op_d        = op_q;
    match_d     = match_q;
    rd_d        = rd_q;
    regad_d     = regad_q;
    ta_d        = ta_q;
    tx_d        = tx_q;
    oe_d        = oe_q;
    out_d       = out_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_strobe_d = 1'b0;
    frame_err_d = 1'b0;
    rf_we       = 1'b0;
    // Address currently being completed (last 4 shifted bits plus this one)
    rf_raddr    = {sh_q[3:0], mdio_bit};
    rf_wdata    = {sh_q[14:0], mdio_bit};

    case (state_q)
      S_HUNT: begin
        if (mdio_bit) begin
          if (ones_q < PRE_SAT) ones_d = ones_q + 6'd1;
        end else if (ones_q >= PRE_SAT) begin
          // First ST bit seen after enough preamble
          state_d = S_ST1;
          ones_d  = '0;
        end else begin
          ones_d = '0;
        end
      end

      S_ST1: begin
        if (mdio_bit == ST_CODE[0]) begin
          state_d = S_OP;
          cnt_d   = '0;
        end else begin
          frame_err_d = 1'b1;
          state_d     = S_HUNT;
        end
      end

      S_OP: begin
        op_d  = {op_q[0], mdio_bit};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd1) begin
          cnt_d = '0;
          if ({op_q[0], mdio_bit} == OP_READ) begin
            rd_d    = 1'b1;
            state_d = S_PHYAD;
          end else if ({op_q[0], mdio_bit} == OP_WRITE) begin
            rd_d    = 1'b0;
            state_d = S_PHYAD;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_HUNT;
          end
        end
      end

      S_PHYAD: begin
        sh_d  = {sh_q[14:0], mdio_bit};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == ADDR_LAST) begin
          match_d = (rf_raddr == PHY_ADDR);
          cnt_d   = '0;
          state_d = S_REGAD;
        end
      end

      S_REGAD: begin
        sh_d  = {sh_q[14:0], mdio_bit};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == ADDR_LAST) begin
          regad_d = rf_raddr;
          cnt_d   = '0;
          if (!match_q) begin
            state_d = S_SKIP;
          end else if (rd_q) begin
            // Snapshot now so a later write cannot tear the reply
            tx_d    = rf_rdata;
            state_d = S_RD_TA;
          end else begin
            state_d = S_WR_TA;
          end
        end
      end

      S_SKIP: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == SKIP_LAST) begin
          cnt_d   = '0;
          state_d = S_HUNT;
        end
      end

      S_RD_TA: begin
        // First TA bit left floating; take the line for the second TA bit
        oe_d    = 1'b1;
        out_d   = 1'b0;
        cnt_d   = '0;
        state_d = S_RD_DATA;
      end

      S_RD_DATA: begin
        if (cnt_q == RD_DONE) begin
          oe_d        = 1'b0;
          out_d       = 1'b0;
          rd_strobe_d = 1'b1;
          cnt_d       = '0;
          state_d     = S_HUNT;
        end else begin
          out_d = tx_q[15];
          tx_d  = {tx_q[14:0], 1'b0};
          cnt_d = cnt_q + 5'd1;
        end
      end

      S_WR_TA: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd0) begin
          ta_d = mdio_bit;
        end else begin
          cnt_d = '0;
          if ({ta_q, mdio_bit} == TA_WRITE) begin
            state_d = S_WR_DATA;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_HUNT;
          end
        end
      end

      S_WR_DATA: begin
        sh_d  = {sh_q[14:0], mdio_bit};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == DATA_LAST) begin
          cnt_d   = '0;
          state_d = S_HUNT;
          // Read-only registers silently swallow the write
          if (!RO_MASK[regad_q]) begin
            rf_we       = 1'b1;
            wr_strobe_d = 1'b1;
            wr_addr_d   = regad_q;
            wr_data_d   = rf_wdata;
          end
        end
      end

      default: begin
        state_d = S_HUNT;
        cnt_d   = '0;
        ones_d  = '0;
        oe_d    = 1'b0;
      end
    endcase
  end

  assign status.o_wr_strobe = wr_strobe_q;
  assign status.o_wr_addr   = wr_addr_q;
  assign status.o_wr_data   = wr_data_q;
  assign status.o_rd_strobe = rd_strobe_q;
  assign status.o_frame_err = frame_err_q;
  assign status.o_busy      = (state_q != S_HUNT);
  assign status.o_mdio_oe   = oe_q;

endmodule
`default_nettype wire

// File: tb/tb_mdio_phy_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdio_phy_responder
// Description : Directed self-checking bench for mdio_phy_responder acting
//               as the MDIO station: builds frames bit by bit, reads the
//               reply off the pulled-up line and tracks event pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mdio_phy_responder;

  logic clk = 1'b0;
  logic rst_n;
  logic drv_oe;
  logic drv_val;
  wire  mdio;

  always #5 clk = ~clk;

  assign mdio = drv_oe ? drv_val : 1'bz;
  pullup (mdio);

  mdio_phy_responder_if ifc ();

  mdio_phy_responder #(
    .PHY_ADDR     (5'd0),
    .PREAMBLE_MIN (32),
    .RO_MASK      (32'h0)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .io_mdio   (mdio),
    .status    (ifc)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Event counters, sampled away from the active edge
  int wr_cnt  = 0;
  int rd_cnt  = 0;
  int err_cnt = 0;
  int oe_cnt  = 0;

  always @(negedge clk) begin
    if (ifc.o_wr_strobe) wr_cnt  <= wr_cnt + 1;
    if (ifc.o_rd_strobe) rd_cnt  <= rd_cnt + 1;
    if (ifc.o_frame_err) err_cnt <= err_cnt + 1;
    if (ifc.o_mdio_oe)   oe_cnt  <= oe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic line_bit();
    return (mdio === 1'b0) ? 1'b0 : 1'b1;
  endfunction

  // Present one bit for the next posedge; returns just after that edge
  task automatic send_bit(input logic b);
    drv_oe  = 1'b1;
    drv_val = b;
    @(posedge clk);
    #1;
  endtask

  // Quiet line held low so idle time never accumulates preamble
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  task automatic send_hdr(input int pre, input logic [1:0] op,
                          input logic [4:0] phy, input logic [4:0] ra);
    for (int i = 0; i < pre; i++) send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(op[1]);
    send_bit(op[0]);
    for (int i = 4; i >= 0; i--) send_bit(phy[i]);
    for (int i = 4; i >= 0; i--) send_bit(ra[i]);
  endtask

  task automatic mdio_read(input int pre, input logic [4:0] phy, input logic [4:0] ra,
                           output logic [15:0] data, output logic ta2, output logic busy);
    send_hdr(pre, 2'b10, phy, ra);
    drv_oe = 1'b0;
    @(posedge clk);
    @(negedge clk);
    ta2  = line_bit();
    busy = ifc.o_busy;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      @(negedge clk);
      data[15-k] = line_bit();
    end
    @(posedge clk);
    #1;
    drv_oe  = 1'b1;
    drv_val = 1'b0;
    idle(3);
  endtask

  task automatic mdio_write(input int pre, input logic [4:0] phy, input logic [4:0] ra,
                            input logic [1:0] ta, input logic [15:0] data);
    send_hdr(pre, 2'b01, phy, ra);
    send_bit(ta[1]);
    send_bit(ta[0]);
    for (int i = 15; i >= 0; i--) send_bit(data[i]);
    idle(3);
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [15:0] d;
    logic        ta2;
    logic        busy;
    int          w0, r0, e0, o0;
    logic [15:0] v;

    rst_n   = 1'b0;
    drv_oe  = 1'b1;
    drv_val = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_addr",   32'(ifc.o_wr_addr),   32'h0);
    check("rst_wr_data",   32'(ifc.o_wr_data),   32'h0);
    check("rst_busy",      32'(ifc.o_busy),      32'h0);
    check("rst_oe",        32'(ifc.o_mdio_oe),   32'h0);
    check("rst_pulses",    32'({ifc.o_wr_strobe, ifc.o_rd_strobe, ifc.o_frame_err}), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // 1: default register reads
    r0 = rd_cnt;
    mdio_read(32, 5'd0, 5'd0, d, ta2, busy);
    check("rd_reg0",     32'(d),    32'h1140);
    check("rd_reg0_ta2", 32'(ta2),  32'h0);
    check("rd_busy",     32'(busy), 32'h1);
    mdio_read(32, 5'd0, 5'd2, d, ta2, busy);
    check("rd_reg2",     32'(d),    32'h0141);
    check("rd_reg2_ta2", 32'(ta2),  32'h0);
    check("rd_strobes",  32'(rd_cnt - r0), 32'd2);

    // 2: write then read back
    w0 = wr_cnt;
    mdio_write(32, 5'd0, 5'd4, 2'b10, 16'hABCD);
    check("wr_strobes", 32'(wr_cnt - w0),     32'd1);
    check("wr_addr",    32'(ifc.o_wr_addr),   32'd4);
    check("wr_data",    32'(ifc.o_wr_data),   32'hABCD);
    mdio_read(32, 5'd0, 5'd4, d, ta2, busy);
    check("rd_reg4_new", 32'(d), 32'hABCD);

    // 3: frames for another PHY are ignored
    w0 = wr_cnt;
    o0 = oe_cnt;
    mdio_write(32, 5'd3, 5'd4, 2'b10, 16'h1234);
    check("other_phy_wr",  32'(wr_cnt - w0), 32'd0);
    check("other_phy_oe",  32'(oe_cnt - o0), 32'd0);
    mdio_read(32, 5'd0, 5'd4, d, ta2, busy);
    check("rd_reg4_kept",  32'(d), 32'hABCD);

    // 4: preamble length boundary
    o0 = oe_cnt;
    r0 = rd_cnt;
    mdio_read(31, 5'd0, 5'd2, d, ta2, busy);
    check("pre31_oe",  32'(oe_cnt - o0), 32'd0);
    check("pre31_rd",  32'(rd_cnt - r0), 32'd0);
    mdio_read(32, 5'd0, 5'd2, d, ta2, busy);
    check("pre32_data", 32'(d),           32'h0141);
    check("pre32_rd",   32'(rd_cnt - r0), 32'd1);

    // 5: bad OP, bad write TA, then a clean frame
    e0 = err_cnt;
    o0 = oe_cnt;
    send_hdr(32, 2'b11, 5'd0, 5'd1);
    idle(18);
    check("op11_err", 32'(err_cnt - e0), 32'd1);
    check("op11_oe",  32'(oe_cnt - o0),  32'd0);
    w0 = wr_cnt;
    mdio_write(32, 5'd0, 5'd5, 2'b11, 16'h5555);
    check("ta11_err", 32'(err_cnt - e0), 32'd2);
    check("ta11_wr",  32'(wr_cnt - w0),  32'd0);
    mdio_read(32, 5'd0, 5'd5, d, ta2, busy);
    check("rd_reg5_after_err", 32'(d), 32'h0000);

    // 6: asynchronous reset in the middle of a read reply
    send_hdr(32, 2'b10, 5'd0, 5'd4);
    drv_oe = 1'b0;
    @(posedge clk);
    for (int k = 0; k <= 8; k++) @(posedge clk);
    #2;
    check("mid_read_oe", 32'(ifc.o_mdio_oe), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_oe_async", 32'(ifc.o_mdio_oe), 32'h0);
    check("rst_busy_async", 32'(ifc.o_busy), 32'h0);
    drv_oe  = 1'b1;
    drv_val = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    mdio_read(32, 5'd0, 5'd4, d, ta2, busy);
    check("rd_reg4_default", 32'(d), 32'h01E1);

    for (int i = 0; i < 32; i++) begin
      v = 16'hA5C3 ^ (16'(i) * 16'h1111);
      mdio_write(32, 5'd0, 5'(i), 2'b10, v);
      mdio_read(32, 5'd0, 5'(i), d, ta2, busy);
      check($sformatf("loop_reg%0d", i), 32'(d), 32'(v));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
